// File: rtl/deint_pkg.sv
// rtl/deint_pkg.sv - rate codes, rate lookup and NCBPS divide helper for the 802.11a deinterleaver
package deint_pkg;

  localparam int MAX_NCBPS = 288;

  localparam logic [3:0] RATE_6M  = 4'b1101;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b0101;
  localparam logic [3:0] RATE_18M = 4'b0111;
  localparam logic [3:0] RATE_24M = 4'b1001;
  localparam logic [3:0] RATE_36M = 4'b1011;
  localparam logic [3:0] RATE_48M = 4'b0001;
  localparam logic [3:0] RATE_54M = 4'b0011;

  typedef enum logic {RD_IDLE, RD_READ} rd_state_e;

  typedef struct packed {
    logic       ok;
    logic [8:0] ncbps;
    logic [2:0] nbpsc;
  } rate_cfg_t;

  function automatic rate_cfg_t rate_lookup(input logic [3:0] code);
    rate_cfg_t cfg;
    case (code)
      RATE_6M,  RATE_9M:  cfg = '{ok: 1'b1, ncbps: 9'd48,  nbpsc: 3'd1};
      RATE_12M, RATE_18M: cfg = '{ok: 1'b1, ncbps: 9'd96,  nbpsc: 3'd2};
      RATE_24M, RATE_36M: cfg = '{ok: 1'b1, ncbps: 9'd192, nbpsc: 3'd4};
      RATE_48M, RATE_54M: cfg = '{ok: 1'b1, ncbps: 9'd288, nbpsc: 3'd6};
      default:            cfg = '{ok: 1'b0, ncbps: 9'd48,  nbpsc: 3'd1};
    endcase
    return cfg;
  endfunction

  // Only four divisors ever occur, so divide by constants instead of a generic divider.
  function automatic logic [12:0] div_ncbps(input logic [12:0] x, input logic [8:0] ncbps);
    logic [12:0] q;
    case (ncbps)
      9'd48:   q = x / 13'd48;
      9'd96:   q = x / 13'd96;
      9'd192:  q = x / 13'd192;
      default: q = x / 13'd288;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/deint_addr_gen.sv
// rtl/deint_addr_gen.sv - combinational map from input bit index j to deinterleaved position k
module deint_addr_gen
  import deint_pkg::*;
(
  input  logic [8:0] j,
  input  logic [8:0] ncbps,
  input  logic [2:0] nbpsc,
  output logic [8:0] k
);

  logic [12:0] j_w, s, f, i_w, i16, g, k_w;

  always_comb begin
    j_w = 13'(j);
    case (nbpsc)
      3'd4:    s = 13'd2;
      3'd6:    s = 13'd3;
      default: s = 13'd1;
    endcase
    f   = div_ncbps(j_w << 4, ncbps);
    i_w = j_w - (j_w % s) + ((j_w + f) % s);
    i16 = i_w << 4;
    g   = div_ncbps(i16, ncbps);
    k_w = i16 - (13'(ncbps) - 13'd1) * g;
    k   = 9'(k_w);
  end

endmodule

// File: rtl/data_deinterleaver.sv
// rtl/data_deinterleaver.sv - ping-pong 802.11a deinterleaver; DEINT_SYMBOL_COUNT_EN adds symbol_count
module data_deinterleaver
  import deint_pkg::*;
(
  input  logic       Clk,
  input  logic       reset,
  input  logic [3:0] rate,
  input  logic       A_in,
  input  logic       B_in,
  input  logic       AB_in_valid,
  output logic       A_out,
  output logic       B_out,
`ifdef DEINT_SYMBOL_COUNT_EN
  output logic [7:0] symbol_count,
`endif
  output logic       AB_out_valid
);

  logic [3:0]                 rate_q, rate_d;
  logic [7:0]                 wr_cnt_q, wr_cnt_d;
  logic                       fill_bank_q, fill_bank_d;
  logic [1:0][MAX_NCBPS-1:0]  mem_q, mem_d;
  rd_state_e                  state_q, state_d;
  logic [7:0]                 rd_cnt_q, rd_cnt_d;
  logic [7:0]                 rd_half_q, rd_half_d;
  logic                       rd_bank_q, rd_bank_d;

  logic [3:0] sym_rate;
  rate_cfg_t  cfg;
  logic [7:0] wr_half;
  logic [8:0] j_a, j_b, k_a, k_b;
  logic       handoff, rd_last;

  // The live rate only matters on the first pair; afterwards the latched code rules.
  assign sym_rate = (wr_cnt_q == 8'd0) ? rate : rate_q;
  assign cfg      = rate_lookup(sym_rate);
  assign wr_half  = cfg.ncbps[8:1];
  assign j_a      = {wr_cnt_q, 1'b0};
  assign j_b      = {wr_cnt_q, 1'b1};

  deint_addr_gen u_addr_a (.j(j_a), .ncbps(cfg.ncbps), .nbpsc(cfg.nbpsc), .k(k_a));
  deint_addr_gen u_addr_b (.j(j_b), .ncbps(cfg.ncbps), .nbpsc(cfg.nbpsc), .k(k_b));

  always_comb begin
    rate_d      = rate_q;
    wr_cnt_d    = wr_cnt_q;
    fill_bank_d = fill_bank_q;
    mem_d       = mem_q;
    handoff     = 1'b0;
    if (AB_in_valid && cfg.ok) begin
      mem_d[fill_bank_q][k_a] = A_in;
      mem_d[fill_bank_q][k_b] = B_in;
      if (wr_cnt_q == 8'd0) rate_d = rate;
      if (wr_cnt_q == wr_half - 8'd1) begin
        handoff     = 1'b1;
        wr_cnt_d    = 8'd0;
        fill_bank_d = ~fill_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 8'd1;
      end
    end
  end

  assign rd_last = (state_q == RD_READ) && (rd_cnt_q == rd_half_q - 8'd1);

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    rd_half_d = rd_half_q;
    if (state_q == RD_READ) rd_cnt_d = rd_cnt_q + 8'd1;
    if (rd_last) state_d = RD_IDLE;
    // A handoff landing on the final read cycle chains straight into the next bank.
    if (handoff && (state_q == RD_IDLE || rd_last)) begin
      state_d   = RD_READ;
      rd_cnt_d  = 8'd0;
      rd_bank_d = fill_bank_q;
      rd_half_d = wr_half;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      rate_q      <= RATE_6M;
      wr_cnt_q    <= 8'd0;
      fill_bank_q <= 1'b0;
      state_q     <= RD_IDLE;
      rd_cnt_q    <= 8'd0;
      rd_half_q   <= 8'd0;
      rd_bank_q   <= 1'b0;
    end else begin
      rate_q      <= rate_d;
      wr_cnt_q    <= wr_cnt_d;
      fill_bank_q <= fill_bank_d;
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_half_q   <= rd_half_d;
      rd_bank_q   <= rd_bank_d;
    end
  end

  // Bank contents need no reset: every symbol rewrites all of its positions before readout.
  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

  assign AB_out_valid = (state_q == RD_READ);
  assign A_out        = AB_out_valid & mem_q[rd_bank_q][{rd_cnt_q, 1'b0}];
  assign B_out        = AB_out_valid & mem_q[rd_bank_q][{rd_cnt_q, 1'b1}];

`ifdef DEINT_SYMBOL_COUNT_EN
  logic [7:0] sym_cnt_q, sym_cnt_d;

  assign sym_cnt_d = rd_last ? sym_cnt_q + 8'd1 : sym_cnt_q;

  always_ff @(posedge Clk) begin
    if (reset) sym_cnt_q <= 8'd0;
    else       sym_cnt_q <= sym_cnt_d;
  end

  assign symbol_count = sym_cnt_q;
`endif

endmodule

// File: doc/data_deinterleaver.md
DATA_DEINTERLEAVER -- requirements
Module: data_deinterleaver

Interface
REQ-001 Clk  input  1  sole clock; all state updates on posedge Clk.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 rate  input  4  802.11a RATE code; sampled only at symbol start.
REQ-004 A_in  input  1  coded bit j=2n of the current input pair.
REQ-005 B_in  input  1  coded bit j=2n+1 of the current input pair.
REQ-006 AB_in_valid  input  1  A_in/B_in valid this cycle; at most one pair per cycle; no backpressure.
REQ-007 A_out  output  1  deinterleaved bit k=2m.
REQ-008 B_out  output  1  deinterleaved bit k=2m+1.
REQ-009 AB_out_valid  output  1  A_out/B_out valid this cycle.

Function
REQ-010 The block SHALL invert the 802.11a interleaver per OFDM symbol of NCBPS bits: input position j maps to output position k.
- s = max(NBPSC/2, 1).
- i = s*floor(j/s) + (j + floor(16j/NCBPS)) mod s.
- k = 16i - (NCBPS-1)*floor(16i/NCBPS).
REQ-011 The rate map SHALL be fixed:
- 1101 or 1111: NCBPS=48, NBPSC=1.
- 0101 or 0111: NCBPS=96, NBPSC=2.
- 1001 or 1011: NCBPS=192, NBPSC=4.
- 0001 or 0011: NCBPS=288, NBPSC=6.
REQ-012 rate SHALL be latched on the first valid pair of each symbol (write count 0); rate changes mid-symbol are ignored.
REQ-013 An unlisted rate code latched at symbol start SHALL cause pairs to be dropped and the write count to stay at 0, so no output is produced.
REQ-014 Buffering SHALL be ping-pong with two banks of 288 bits each; each input pair is written at addresses k(2n) and k(2n+1) of the fill bank.
REQ-015 On the NCBPS/2-th valid pair the fill bank SHALL be handed to the read side and filling SHALL switch to the other bank.
REQ-016 Read FSM states:
- IDLE -> READ on bank handoff.
- READ -> IDLE after NCBPS/2 pairs.
- READ -> READ (other bank) if a handoff occurs in its final cycle.
REQ-017 AB_out_valid SHALL rise the cycle after the last input pair of a symbol is sampled and stay high for exactly NCBPS/2 consecutive cycles.
REQ-018 During a read, output pair m = (bit 2m, bit 2m+1) in increasing m; output NCBPS/rate are those latched for that symbol.
REQ-019 Back-to-back symbols at full input rate SHALL produce continuous AB_out_valid with no gap and no overrun.
REQ-020 When AB_out_valid=0, A_out and B_out SHALL be driven 0.

Reset
REQ-021 reset SHALL take priority over all other inputs.
REQ-022 On reset:
- AB_out_valid, A_out, B_out = 0.
- Write and read counts = 0; fill bank = 0; read FSM = IDLE.
- Latched rate = 1101.
REQ-023 Reset mid-symbol or mid-read SHALL discard all partial and pending data, with no output after reset deasserts until a new full symbol arrives.

Configuration
REQ-024 With DEINT_SYMBOL_COUNT_EN defined, the block SHALL add output symbol_count[7:0]:
- reset to 0;
- increments the cycle after each symbol's final output pair;
- wraps 255->0.
REQ-025 Without DEINT_SYMBOL_COUNT_EN, the port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-026 Shared package deint_pkg SHALL hold:
- the rate-code localparams;
- the NCBPS/NBPSC lookup function;
- MAX_NCBPS=288.
REQ-027 Address mapping SHALL be a combinational sub-module deint_addr_gen (inputs j, NCBPS, NBPSC; output k), instantiated twice (A and B).

Verification
REQ-028 rate=1101, input bit j=3 set, all others 0, 24 pairs:
- 24 valid output cycles starting 1 cycle after pair 24;
- only pair 0 has B_out=1 (k=1).
REQ-029 rate=0101, input bit j=1 set, 48 pairs:
- 48 output cycles;
- only pair 8 has A_out=1 (k=16).
REQ-030 rate=1001, input bit j=13 set, 96 pairs:
- only output pair 0 has B_out=1;
- exact 96-cycle valid window.
REQ-031 rate=0001, three back-to-back symbols at full rate:
- continuous 432-cycle AB_out_valid;
- output data matches the reference model;
- symbol_count=3 when the macro is defined.
REQ-032 reset asserted after 10 pairs of a 48-bit symbol, then a full new symbol sent: exactly one 24-cycle output burst, holding only the new data.
REQ-033 rate changed from 1101 to 0001 mid-symbol: symbol still completes after 24 pairs; the next symbol uses 0001.
